hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Next-generation forwarding/hazard controller for the RISC-TOY pipeline.
- Generalises two-source, two-stage forwarding:
  - NSRC EX-stage source operands.
  - NFWD forwarding stages.
- Adds sequential hazard handling:
  - load-use stall;
  - scoreboard/FSM for one multi-cycle custom-IP operation;
  - structural stall;
  - completion write-back pulse.
- Sits between the ID/EX pipeline registers and the EX operand muxes.
- Drives the ID stall and EX-bubble controls.

Parameters:
AW, 5, register address width; address 0 is the hard-wired zero register.
NSRC, 2, number of EX source operands.
NFWD, 2, forwarding stages; index 0 = youngest (MEM), NFWD-1 = oldest (WB).
LATW, 4, multi-cycle latency field width.
SELW, $clog2(NFWD+1), width of each forward-select field (derived; do not override).

Ports:
CLK  in  1  clock.
RST  in  1  reset, asynchronous, active-high.
src_ex  in  NSRC*AW  EX source register addresses; operand i occupies [i*AW +: AW].
src_id  in  NSRC*AW  ID source register addresses, used for stall detection.
src_used_id  in  NSRC  per-operand valid bit for ID-stage instruction.
dst  in  NFWD*AW  destination address per forwarding stage.
dst_we  in  NFWD  RegWrite per forwarding stage.
dst_ex  in  AW  destination of the instruction currently in EX.
memrd_ex  in  1  instruction in EX is a load.
mc_start  in  1  EX issues a multi-cycle op this cycle.
mc_dst  in  AW  destination of the multi-cycle op.
mc_lat  in  LATW  op latency in cycles (0 treated as 1).
fwd_sel  out  NSRC*SELW  per-operand select: 0 = regfile, k = stage k-1.
stall_id  out  1  hold PC and IF/ID.
bubble_ex  out  1  insert NOP into ID/EX.
mc_busy  out  1  multi-cycle unit occupied.
mc_wb  out  1  one-cycle pulse: multi-cycle result ready for write-back.
mc_wb_dst  out  AW  destination register accompanying mc_wb.

Behaviour:
- fwd_sel is combinational.
  - For each operand, select the lowest stage index k where: dst_we[k], dst[k] != 0, and dst[k] == src_ex[i].
  - The youngest stage wins; if no stage matches, select 0.
  - A src_ex of 0 never forwards.
- Reset (RST high, asynchronous): FSM to IDLE; counter = 0; mc_wb = 0; mc_wb_dst = 0; mc_busy = 0.
  - Combinational outputs are still driven from their inputs during reset.
- FSM states:
  - IDLE: on mc_start, load cnt = max(mc_lat,1)-1, latch mc_dst, go to BUSY.
  - BUSY: mc_busy = 1. If cnt == 0, go to DONE; else decrement cnt.
  - DONE: mc_wb = 1 and mc_wb_dst = latched dst for exactly this cycle; mc_busy = 1. Next state is IDLE, or BUSY if mc_start is asserted in this same cycle (back-to-back ops allowed).
- Total mc_start-to-mc_wb latency = max(mc_lat,1)+1 cycles.
- stall_id = OR of three conditions:
  - (a) Load-use: memrd_ex, dst_ex != 0, and some used src_id matches dst_ex. Lasts exactly 1 cycle per load.
  - (b) Scoreboard: FSM in BUSY, and some used src_id equals the latched dst (nonzero).
  - (c) Structural: FSM in BUSY and the ID instruction would issue mc_start. Detected by the caller as mc_start while BUSY; mc_start is ignored while in BUSY.
- bubble_ex = stall_id.
- mc_start while in DONE is accepted.
- Zero-register destination on a multi-cycle op:
  - the op still runs and pulses mc_wb;
  - the scoreboard never stalls on it.
- RST asserted mid-operation aborts the op; no mc_wb pulse is produced.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - adds output stall_cnt (32 bits);
  - increments on every cycle with stall_id = 1;
  - saturates at 0xFFFFFFFF;
  - clears on RST.
- When undefined: the port and logic are absent, with no other change.

Decomposition:
- Package hazard_pkg holds:
  - FSM state enum (IDLE, BUSY, DONE);
  - the zero-register constant;
  - the forward-select encoding constant FWD_RF = 0.
- One sub-module, fwd_sel_prio: per-operand priority encoder over NFWD stages, instantiated NSRC times via generate.

Test Plan:
- Forward priority: dst = {MEM:r3, WB:r3}, both we = 1, src_ex0 = r3 -> fwd_sel0 = 1. Drop MEM we -> fwd_sel0 = 2. Set src_ex0 = r0 -> fwd_sel0 = 0.
- Load-use: memrd_ex = 1, dst_ex = r5, src_id1 = r5 with used = 1 -> stall_id = bubble_ex = 1 for exactly 1 cycle. With src_used_id1 = 0 -> no stall.
- Multi-cycle: mc_start with mc_lat = 3, mc_dst = r7 -> mc_busy for 4 cycles; mc_wb pulses 4 cycles after the mc_start edge with mc_wb_dst = r7. src_id0 = r7 stalls throughout BUSY and releases in DONE.
- Boundaries: mc_lat = 0 -> mc_wb 2 cycles after start. mc_start in DONE -> immediate re-entry to BUSY with no idle cycle. mc_dst = r0 -> no scoreboard stall.
- Reset mid-op: assert RST 2 cycles into BUSY -> mc_busy = 0 asynchronously and no mc_wb pulse ever follows.
- Parametrisation and counter: NSRC = 3, NFWD = 3 with matches in all stages -> youngest selected for each operand. With HAZARD_PERF_CNT_EN defined, 5 stall cycles -> stall_cnt = 5.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Holds the multi-cycle FSM states and the register/select encodings.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    localparam int unsigned ZERO_REG = 0;
    localparam int unsigned FWD_RF   = 0;

endpackage

// File: rtl/fwd_sel_prio.sv
// Per-operand forwarding priority encoder over NFWD pipeline stages.
// Stage 0 is the youngest and therefore has the highest priority.
module fwd_sel_prio
    import hazard_pkg::*;
#(
    parameter  int AW   = 5,
    parameter  int NFWD = 2,
    localparam int SELW = $clog2(NFWD + 1)
) (
    input  logic [AW-1:0]      src_i,
    input  logic [NFWD*AW-1:0] dst_i,
    input  logic [NFWD-1:0]    dst_we_i,
    output logic [SELW-1:0]    sel_o
);

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    // Walk oldest to youngest so the youngest match is the last write.
    always_comb begin
        sel_o = SELW'(FWD_RF);
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (dst_we_i[k] && src_i != ZR &&
                dst_i[k*AW +: AW] == src_i) begin
                sel_o = SELW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding select, load-use/scoreboard/structural stall and multi-cycle op tracker.
// Define HAZARD_PERF_CNT_EN to add the saturating stall_cnt output.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter  int AW   = 5,
    parameter  int NSRC = 2,
    parameter  int NFWD = 2,
    parameter  int LATW = 4,
    localparam int SELW = $clog2(NFWD + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NSRC*AW-1:0]   src_ex,
    input  logic [NSRC*AW-1:0]   src_id,
    input  logic [NSRC-1:0]      src_used_id,
    input  logic [NFWD*AW-1:0]   dst,
    input  logic [NFWD-1:0]      dst_we,
    input  logic [AW-1:0]        dst_ex,
    input  logic                 memrd_ex,
    input  logic                 mc_start,
    input  logic [AW-1:0]        mc_dst,
    input  logic [LATW-1:0]      mc_lat,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic                 mc_busy,
    output logic                 mc_wb,
    output logic [AW-1:0]        mc_wb_dst
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    mc_state_e       state_q, state_d;
    logic [LATW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [LATW-1:0] lat_m1;
    logic            in_busy;
    logic            lu_hit;
    logic            sb_hit;

    for (genvar i = 0; i < NSRC; i++) begin : g_prio
        fwd_sel_prio #(
            .AW   (AW),
            .NFWD (NFWD)
        ) u_prio (
            .src_i    (src_ex[i*AW +: AW]),
            .dst_i    (dst),
            .dst_we_i (dst_we),
            .sel_o    (fwd_sel[i*SELW +: SELW])
        );
    end

    // A zero latency behaves like one cycle.
    assign lat_m1 = (mc_lat == '0) ? '0 : mc_lat - LATW'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        unique case (state_q)
            IDLE: begin
                if (mc_start) begin
                    cnt_d   = lat_m1;
                    dst_d   = mc_dst;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - LATW'(1);
                end
            end
            DONE: begin
                if (mc_start) begin
                    cnt_d   = lat_m1;
                    dst_d   = mc_dst;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_busy   = (state_q == BUSY);
    assign mc_busy   = (state_q != IDLE);
    assign mc_wb     = (state_q == DONE);
    assign mc_wb_dst = mc_wb ? dst_q : '0;

    always_comb begin
        lu_hit = 1'b0;
        sb_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_used_id[i]) begin
                if (src_id[i*AW +: AW] == dst_ex) lu_hit = 1'b1;
                if (src_id[i*AW +: AW] == dst_q)  sb_hit = 1'b1;
            end
        end
    end

    // Scoreboard releases in DONE: the result is written back that cycle.
    assign stall_id = (memrd_ex && dst_ex != ZR && lu_hit) ||
                      (in_busy && dst_q != ZR && sb_hit) ||
                      (in_busy && mc_start);

    assign bubble_ex = stall_id;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else if (stall_id && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl with a cycle-indexed reference model.
// A second instance covers the NSRC=3 / NFWD=3 forwarding configuration.
module tb_hazard_fwd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [9:0]  src_ex = '0;
    logic [9:0]  src_id = '0;
    logic [1:0]  used = '0;
    logic [9:0]  dst = '0;
    logic [1:0]  dst_we = '0;
    logic [4:0]  dst_ex = '0;
    logic        memrd = 1'b0;
    logic        mc_start = 1'b0;
    logic [4:0]  mc_dst = '0;
    logic [3:0]  mc_lat = '0;
    logic [3:0]  fwd_sel;
    logic        stall_id, bubble_ex, mc_busy, mc_wb;
    logic [4:0]  mc_wb_dst;

    logic [14:0] src_ex3 = '0;
    logic [14:0] dst3 = '0;
    logic [2:0]  we3 = '0;
    logic [5:0]  fwd_sel3;
    logic        stall3, bub3, busy3, wb3;
    logic [4:0]  wbd3;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, stall_cnt3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    hazard_fwd_ctrl dut (
        .CLK(CLK), .RST(RST),
        .src_ex(src_ex), .src_id(src_id), .src_used_id(used),
        .dst(dst), .dst_we(dst_we), .dst_ex(dst_ex), .memrd_ex(memrd),
        .mc_start(mc_start), .mc_dst(mc_dst), .mc_lat(mc_lat),
        .fwd_sel(fwd_sel), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .mc_busy(mc_busy), .mc_wb(mc_wb), .mc_wb_dst(mc_wb_dst)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    hazard_fwd_ctrl #(.NSRC(3), .NFWD(3)) dut3 (
        .CLK(CLK), .RST(RST),
        .src_ex(src_ex3), .src_id(15'd0), .src_used_id(3'd0),
        .dst(dst3), .dst_we(we3), .dst_ex(5'd0), .memrd_ex(1'b0),
        .mc_start(1'b0), .mc_dst(5'd0), .mc_lat(4'd0),
        .fwd_sel(fwd_sel3), .stall_id(stall3), .bubble_ex(bub3),
        .mc_busy(busy3), .mc_wb(wb3), .mc_wb_dst(wbd3)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt3)
`endif
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the op started in cycle st_cyc writes back in wb_cyc.
    int          cyc = 0;
    int          st_cyc = 0;
    int          wb_cyc = -1;
    logic [4:0]  m_dst = '0;
    int          m_cnt = 0;

    function automatic int exp_sel(int i, int nfwd, logic [14:0] s,
                                   logic [14:0] d, logic [2:0] w);
        logic [4:0] r;
        r = s[i*5 +: 5];
        if (r == 5'd0) return 0;
        for (int k = 0; k < nfwd; k++)
            if (w[k] && d[k*5 +: 5] == r) return k + 1;
        return 0;
    endfunction

    function automatic bit m_busy();
        return !RST && wb_cyc >= 0 && cyc > st_cyc && cyc <= wb_cyc;
    endfunction

    function automatic bit m_wb();
        return !RST && wb_cyc == cyc;
    endfunction

    function automatic bit uses(logic [4:0] r);
        return (used[0] && src_id[4:0] == r) || (used[1] && src_id[9:5] == r);
    endfunction

    function automatic bit m_stall();
        bit lu, blk;
        lu  = memrd && dst_ex != 5'd0 && uses(dst_ex);
        blk = m_busy() && !m_wb() &&
              (mc_start || (m_dst != 5'd0 && uses(m_dst)));
        return lu || blk;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            cyc = 0;
            wb_cyc = -1;
            st_cyc = 0;
            m_cnt = 0;
        end else begin
            if (m_stall()) m_cnt++;
            if (mc_start && !(m_busy() && !m_wb())) begin
                st_cyc = cyc;
                wb_cyc = cyc + ((mc_lat == 4'd0) ? 1 : int'(mc_lat)) + 1;
                m_dst  = mc_dst;
            end
            cyc++;
        end
    end

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++)
            chk("fwd_sel", 32'(fwd_sel[i*2 +: 2]),
                32'(exp_sel(i, 2, {5'd0, src_ex}, {5'd0, dst}, {1'b0, dst_we})));
        for (int i = 0; i < 3; i++)
            chk("fwd_sel3", 32'(fwd_sel3[i*2 +: 2]),
                32'(exp_sel(i, 3, src_ex3, dst3, we3)));
        chk("stall_id", 32'(stall_id), 32'(m_stall()));
        chk("bubble_ex", 32'(bubble_ex), 32'(m_stall()));
        chk("mc_busy", 32'(mc_busy), 32'(m_busy()));
        chk("mc_wb", 32'(mc_wb), 32'(m_wb()));
        chk("mc_wb_dst", 32'(mc_wb_dst), m_wb() ? 32'(m_dst) : 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, RST ? 32'd0 : 32'(m_cnt));
`endif
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one op and watches up to 10 cycles for its write-back.
    task automatic run_mc(input logic [3:0] lat, input logic [4:0] d,
                          output int first, output int nbusy,
                          output int nstall, output logic [4:0] wdst);
        first = -1;
        nbusy = 0;
        nstall = 0;
        wdst = 'x;
        mc_start = 1'b1;
        mc_lat = lat;
        mc_dst = d;
        tick();
        mc_start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            #2;
            if (mc_busy) nbusy++;
            if (mc_wb && first < 0) begin
                first = n;
                wdst = mc_wb_dst;
            end
            if (mc_busy && !mc_wb && stall_id) nstall++;
            tick();
        end
    endtask

    int first, nbusy, nstall, nwb;
    logic [4:0] wdst;

    initial begin
        tick();
        #2;
        chk("rst_busy", 32'(mc_busy), 32'd0);
        chk("rst_wb", 32'(mc_wb), 32'd0);
        chk("rst_wbd", 32'(mc_wb_dst), 32'd0);
        tick();
        RST = 1'b0;

        dst = {5'd3, 5'd3};
        dst_we = 2'b11;
        src_ex = {5'd0, 5'd3};
        #2 chk("fwd_mem", 32'(fwd_sel[1:0]), 32'd1);
        tick();
        dst_we = 2'b10;
        #2 chk("fwd_wb", 32'(fwd_sel[1:0]), 32'd2);
        tick();
        src_ex = {5'd0, 5'd0};
        #2 chk("fwd_r0", 32'(fwd_sel[1:0]), 32'd0);
        tick();
        dst = {5'd9, 5'd3};
        dst_we = 2'b11;
        src_ex = {5'd3, 5'd9};
        #2 chk("fwd_mix", 32'(fwd_sel), 32'b0110);
        tick();

        dst3 = {5'd4, 5'd4, 5'd4};
        we3 = 3'b111;
        src_ex3 = {5'd4, 5'd4, 5'd4};
        #2 chk("fwd3_all", 32'(fwd_sel3), 32'b010101);
        tick();
        dst3 = {5'd2, 5'd2, 5'd1};
        src_ex3 = {5'd3, 5'd2, 5'd1};
        #2 chk("fwd3_mix", 32'(fwd_sel3), 32'b001001);
        tick();
        we3 = 3'b101;
        #2 chk("fwd3_old", 32'(fwd_sel3), 32'b001101);
        tick();

        memrd = 1'b1;
        dst_ex = 5'd5;
        src_id = {5'd5, 5'd0};
        used = 2'b10;
        #2 chk("lu_stall", 32'({stall_id, bubble_ex}), 32'b11);
        tick();
        memrd = 1'b0;
        #2 chk("lu_once", 32'(stall_id), 32'd0);
        tick();
        memrd = 1'b1;
        used = 2'b01;
        #2 chk("lu_unused", 32'(stall_id), 32'd0);
        tick();
        memrd = 1'b0;
        dst_ex = 5'd0;

        src_id = {5'd0, 5'd7};
        used = 2'b01;
        run_mc(4'd3, 5'd7, first, nbusy, nstall, wdst);
        chk("mc3_wb_at", 32'(first), 32'd4);
        chk("mc3_busy", 32'(nbusy), 32'd4);
        chk("mc3_stall", 32'(nstall), 32'd3);
        chk("mc3_dst", 32'(wdst), 32'd7);

        run_mc(4'd0, 5'd7, first, nbusy, nstall, wdst);
        chk("mc0_wb_at", 32'(first), 32'd2);
        chk("mc0_busy", 32'(nbusy), 32'd2);

        src_id = {5'd0, 5'd0};
        used = 2'b11;
        run_mc(4'd2, 5'd0, first, nbusy, nstall, wdst);
        chk("r0_wb_at", 32'(first), 32'd3);
        chk("r0_nostall", 32'(nstall), 32'd0);
        chk("r0_dst", 32'(wdst), 32'd0);
        used = 2'b00;

        mc_start = 1'b1;
        mc_lat = 4'd1;
        mc_dst = 5'd9;
        tick();
        mc_start = 1'b0;
        #2 chk("b2b_busy1", 32'({mc_busy, mc_wb}), 32'b10);
        tick();
        #2 chk("b2b_wb1", 32'({mc_wb, mc_wb_dst}), {26'd0, 1'b1, 5'd9});
        mc_start = 1'b1;
        mc_lat = 4'd2;
        mc_dst = 5'd10;
        tick();
        #2 chk("b2b_reenter", 32'({mc_busy, mc_wb}), 32'b10);
        chk("struct_stall", 32'(stall_id), 32'd1);
        tick();
        mc_start = 1'b0;
        #2 chk("b2b_busy2", 32'({mc_busy, mc_wb}), 32'b10);
        tick();
        #2 chk("b2b_wb2", 32'({mc_wb, mc_wb_dst}), {26'd0, 1'b1, 5'd10});
        tick();
        #2 chk("b2b_idle", 32'(mc_busy), 32'd0);

        mc_start = 1'b1;
        mc_lat = 4'd6;
        mc_dst = 5'd7;
        tick();
        mc_start = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        #1 chk("rst_async", 32'(mc_busy), 32'd0);
        tick();
        RST = 1'b0;
        nwb = 0;
        for (int n = 0; n < 10; n++) begin
            #2;
            if (mc_wb) nwb++;
            tick();
        end
        chk("rst_no_wb", 32'(nwb), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
        RST = 1'b1;
        tick();
        RST = 1'b0;
        memrd = 1'b1;
        dst_ex = 5'd5;
        src_id = {5'd0, 5'd5};
        used = 2'b01;
        for (int n = 0; n < 5; n++) tick();
        memrd = 1'b0;
        #2 chk("stall_cnt5", stall_cnt, 32'd5);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
